// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit -- single-stage registered integer ALU / branch resolver.
//
// One operation can be issued per cycle. Its result is registered and
// broadcast on the cycle after issue.
//
// Ports
//   clk_in          system clock; all state updates on its rising edge
//   rst_in          asynchronous active-high reset; clears every output
//   rdy_in          global ready; low freezes all output registers
//   clear_flag      flush on mispredict; clears outputs and drops the op
//   in_valid        issue strobe
//   in_op[4:0]      opcode (0 NOP .. 20 BGEU; 21-31 treated as NOP)
//   in_use_imm      selects operand B: 1 = in_imm, 0 = in_vj
//   in_vi, in_vj    operand A and register operand B
//   in_imm, in_pc   immediate and instruction PC
//   in_rob_id[4:0]  destination ROB tag
//   out_ready       result valid strobe on the common data bus
//   out_rob_id      tag of the broadcast result
//   out_val         result value
//   out_is_br       op was a jump or branch
//   out_br_taken    control flow redirected
//   out_br_target   resolved next PC for control-flow ops
// ---------------------------------------------------------------------------
module alu_unit (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_flag,
  input  logic        in_valid,
  input  logic [4:0]  in_op,
  input  logic        in_use_imm,
  input  logic [31:0] in_vi,
  input  logic [31:0] in_vj,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rob_id,
  output logic        out_ready,
  output logic [4:0]  out_rob_id,
  output logic [31:0] out_val,
  output logic        out_is_br,
  output logic        out_br_taken,
  output logic [31:0] out_br_target
);

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_AUIPC = 5'd12;
  localparam logic [4:0] OP_JAL   = 5'd13;
  localparam logic [4:0] OP_JALR  = 5'd14;
  localparam logic [4:0] OP_BEQ   = 5'd15;
  localparam logic [4:0] OP_BNE   = 5'd16;
  localparam logic [4:0] OP_BLT   = 5'd17;
  localparam logic [4:0] OP_BGE   = 5'd18;
  localparam logic [4:0] OP_BLTU  = 5'd19;
  localparam logic [4:0] OP_BGEU  = 5'd20;

  logic [31:0] opnd_b;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;

  // Branch comparisons always use the register operand, never the immediate.
  logic br_eq;
  logic br_lt;
  logic br_ltu;

  logic        op_live;
  logic [31:0] res_val;
  logic        res_is_br;
  logic        res_taken;
  logic [31:0] res_target;

  assign opnd_b      = in_use_imm ? in_imm : in_vj;
  assign shamt       = opnd_b[4:0];
  assign pc_plus4    = in_pc + 32'd4;
  assign pc_plus_imm = in_pc + in_imm;
  assign br_eq       = (in_vi == in_vj);
  assign br_lt       = ($signed(in_vi) < $signed(in_vj));
  assign br_ltu      = (in_vi < in_vj);

  always_comb begin
    op_live    = 1'b1;
    res_val    = 32'd0;
    res_is_br  = 1'b0;
    res_taken  = 1'b0;
    res_target = 32'd0;
    case (in_op)
      OP_ADD:   res_val = in_vi + opnd_b;
      OP_SUB:   res_val = in_vi - opnd_b;
      OP_AND:   res_val = in_vi & opnd_b;
      OP_OR:    res_val = in_vi | opnd_b;
      OP_XOR:   res_val = in_vi ^ opnd_b;
      OP_SLL:   res_val = in_vi << shamt;
      OP_SRL:   res_val = in_vi >> shamt;
      OP_SRA:   res_val = $unsigned($signed(in_vi) >>> shamt);
      OP_SLT:   res_val = {31'd0, $signed(in_vi) < $signed(opnd_b)};
      OP_SLTU:  res_val = {31'd0, in_vi < opnd_b};
      OP_LUI:   res_val = in_imm;
      OP_AUIPC: res_val = pc_plus_imm;
      OP_JAL: begin
        res_val    = pc_plus4;
        res_is_br  = 1'b1;
        res_taken  = 1'b1;
        res_target = pc_plus_imm;
      end
      OP_JALR: begin
        res_val    = pc_plus4;
        res_is_br  = 1'b1;
        res_taken  = 1'b1;
        res_target = (in_vi + in_imm) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_is_br = 1'b1;
        case (in_op)
          OP_BEQ:  res_taken = br_eq;
          OP_BNE:  res_taken = ~br_eq;
          OP_BLT:  res_taken = br_lt;
          OP_BGE:  res_taken = ~br_lt;
          OP_BLTU: res_taken = br_ltu;
          default: res_taken = ~br_ltu;
        endcase
        res_target = res_taken ? pc_plus_imm : pc_plus4;
      end
      // OP_NOP and the unused codes 21-31 broadcast nothing.
      default:  op_live = 1'b0;
    endcase
  end

  // Reset beats flush, flush beats the ready hold; an idle or NOP
  // cycle clears the outputs so a result is valid exactly one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_ready     <= 1'b0;
      out_rob_id    <= 5'd0;
      out_val       <= 32'd0;
      out_is_br     <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= 32'd0;
    end else if (clear_flag) begin
      out_ready     <= 1'b0;
      out_rob_id    <= 5'd0;
      out_val       <= 32'd0;
      out_is_br     <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= 32'd0;
    end else if (rdy_in) begin
      if (in_valid && op_live) begin
        out_ready     <= 1'b1;
        out_rob_id    <= in_rob_id;
        out_val       <= res_val;
        out_is_br     <= res_is_br;
        out_br_taken  <= res_taken;
        out_br_target <= res_target;
      end else begin
        out_ready     <= 1'b0;
        out_rob_id    <= 5'd0;
        out_val       <= 32'd0;
        out_is_br     <= 1'b0;
        out_br_taken  <= 1'b0;
        out_br_target <= 32'd0;
      end
    end
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL expose: clk_in  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL expose: rst_in  input  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: rdy_in  input  1  global ready; low = hold all state.
REQ-004 SHALL expose: clear_flag  input  1  mispredict flush; discard all in-flight work.
REQ-005 SHALL expose: in_valid  input  1  issue strobe from reservation station, one op per cycle.
REQ-006 SHALL expose: in_op  input  5  operation code per REQ-014.
REQ-007 SHALL expose: in_use_imm  input  1  1 = operand B is in_imm, 0 = in_vj.
REQ-008 SHALL expose: in_vi, in_vj, in_imm, in_pc  input  32 each  operand A, operand B, immediate, instruction PC.
REQ-009 SHALL expose: in_rob_id  input  5  destination ROB tag.
REQ-010 SHALL expose: out_ready  output  1  result broadcast valid (CDB strobe).
REQ-011 SHALL expose: out_rob_id  output  5; out_val  output  32  tag and result value.
REQ-012 SHALL expose: out_is_br  output  1; out_br_taken  output  1; out_br_target  output  32  control-flow resolution.

Function
REQ-013 SHALL be a single-stage registered unit: op accepted on edge N appears on outputs after edge N, valid exactly one cycle unless a new op is accepted on edge N+1.
REQ-014 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 LUI, 12 AUIPC, 13 JAL, 14 JALR, 15 BEQ, 16 BNE, 17 BLT, 18 BGE, 19 BLTU, 20 BGEU; codes 21-31 behave as NOP.
REQ-015 B = in_use_imm ? in_imm : in_vj; ALU ops 1-10 compute on (in_vi, B).
REQ-016 Shifts SHALL use B[4:0] only; SRA sign-fills from in_vi[31].
REQ-017 SLT signed, SLTU unsigned compare; result 32'd1 or 32'd0.
REQ-018 All arithmetic SHALL be 32-bit modulo 2^32; no overflow flag.
REQ-019 LUI: val = in_imm; AUIPC: val = in_pc + in_imm.
REQ-020 JAL: val = in_pc + 4, is_br = 1, taken = 1, target = in_pc + in_imm.
REQ-021 JALR: val = in_pc + 4, is_br = 1, taken = 1, target = (in_vi + in_imm) & ~32'd1.
REQ-022 Branches 15-20: compare in_vi vs in_vj (never imm); is_br = 1; taken per condition; target = taken ? in_pc + in_imm : in_pc + 4; val = 0.
REQ-023 Non-control ops SHALL drive out_is_br = 0, out_br_taken = 0, out_br_target = 0.
REQ-024 in_valid = 0 or NOP-class op at an active edge SHALL set out_ready = 0 and clear all other outputs to 0.
REQ-025 rdy_in = 0 SHALL freeze every output register; in_valid during that cycle is ignored (upstream must hold).
REQ-026 clear_flag = 1 at an edge SHALL clear all outputs to 0 regardless of in_valid and rdy_in; an op presented that cycle is dropped.
REQ-027 Back-to-back ops SHALL be accepted every cycle; no stall output exists.

Reset
REQ-028 rst_in high SHALL immediately, independent of clk_in, force out_ready, out_rob_id, out_val, out_is_br, out_br_taken, out_br_target to 0.
REQ-029 Reset asserted mid-operation SHALL discard the pending result; first valid output after release needs a fresh in_valid.
REQ-030 rst_in SHALL take priority over clear_flag and rdy_in.

Verification
REQ-031 ADD: vi=5, vj=7, use_imm=0, rob=3 -> next cycle out_ready=1, rob_id=3, val=12; following idle cycle out_ready=0.
REQ-032 SRA/SLTU: vi=0x80000000, imm=4, use_imm=1, SRA -> val=0xF8000000; SLTU vi=1, vj=0xFFFFFFFF -> val=1; SLT same operands -> val=0.
REQ-033 BLT: pc=0x100, vi=-1, vj=1, imm=0x20 -> is_br=1, taken=1, target=0x120; BGEU same operands -> taken=1, target=0x120; BEQ -> taken=0, target=0x104.
REQ-034 JALR: pc=0x40, vi=0x1001, imm=2 -> val=0x44, target=0x1002, taken=1.
REQ-035 Hold/flush: accept ADD, drop rdy_in 2 cycles -> outputs unchanged; assert clear_flag with in_valid=1 -> out_ready=0 next cycle.
REQ-036 Async reset: assert rst_in between clock edges while out_ready=1 -> outputs 0 before next edge; stay 0 until new in_valid after release.
